lsu_ram_responder: RTL
======================

LSU_RAM_RESPONDER -- requirements
Module: lsu_ram_responder

Interface
REQ-001 Parameters SHALL be, one per line: name, default, meaning.
- DEPTH_WORDS, 256, number of 32-bit words in the storage array.
- READ_LATENCY, 2, number of cycles from read accept to read response; legal range 1..15.
- BASE_ADDR, 32'h0000_0000, byte address of word 0.

REQ-002 Ports SHALL be, one per line: name, direction, width, meaning.
- clk, input, 1, sole clock; all state updates on the rising edge.
- rst, input, 1, synchronous, active-high reset.
- ram_req, input, 1, request valid from the LSU.
- ram_write_enable, input, 1, 1 = store, 0 = load; qualified by ram_req.
- ram_address, input, 32, byte address.
- ram_data_in, input, 32, store data.
- ram_byte_en, input, 4, store byte lanes; bit n enables data[8n+7:8n].
- ram_ready, output, 1, responder can accept a request this cycle.
- ram_data_out, output, 32, load data; valid only with ram_resp_valid.
- ram_resp_valid, output, 1, one-cycle response pulse.
- ram_err, output, 1, error flag; valid only with ram_resp_valid.

Function
REQ-003 A request SHALL be accepted on a rising edge where ram_req=1 and ram_ready=1; ram_req while ram_ready=0 SHALL be ignored.
REQ-004 The FSM SHALL have three states: IDLE (ram_ready=1), WAIT (ram_ready=0, latency counter running) and RESP (ram_ready=0, ram_resp_valid=1).
REQ-005 Transitions from IDLE SHALL be as follows.
- Accepted error, write, or read with READ_LATENCY=1: go to RESP.
- Accepted read with READ_LATENCY>1: go to WAIT, with counter loaded to READ_LATENCY-2.
REQ-006 WAIT SHALL decrement the counter each cycle and go to RESP on the edge where the counter equals 0.
REQ-007 RESP SHALL last exactly one cycle, then return to IDLE, giving one request per 2 cycles (write/error) or per READ_LATENCY+1 cycles (read).
REQ-008 A request SHALL be an error when ram_address[1:0]!=0 or ram_address<BASE_ADDR or ((ram_address-BASE_ADDR)>>2)>=DEPTH_WORDS.
REQ-009 The word index SHALL be (ram_address-BASE_ADDR)>>2, computed in 32-bit unsigned arithmetic; wrap-around of the subtraction SHALL be treated as out of range.
REQ-010 An accepted error request SHALL not modify the array, and its response SHALL have ram_err=1 and ram_data_out=0.
REQ-011 An accepted valid write SHALL update the enabled byte lanes on the accept edge and leave disabled lanes unchanged.
REQ-012 A write response SHALL have ram_err=0 and ram_data_out=0.
REQ-013 A write with ram_byte_en=4'b0000 SHALL change no array contents and SHALL still respond with ram_err=0.
REQ-014 An accepted valid read SHALL capture the array word on the accept edge; ram_data_out SHALL present that word in the RESP cycle with ram_err=0.
REQ-015 ram_byte_en SHALL be ignored for reads.
REQ-016 Address, data and byte enables SHALL be registered at accept; input changes after accept SHALL not affect the response.
REQ-017 Outside RESP, ram_resp_valid=0, ram_err=0 and ram_data_out=0.

Reset
REQ-018 While rst=1 at an edge: state<=IDLE, counter<=0, ram_ready<=0, ram_resp_valid<=0, ram_err<=0, ram_data_out<=0.
REQ-019 ram_ready SHALL first be 1 in the cycle after the first edge with rst=0.
REQ-020 Reset asserted in WAIT or RESP SHALL abort the transaction with no response pulse.
REQ-021 A write already accepted before reset SHALL remain committed, and array contents SHALL not be cleared by reset.
REQ-022 rst=1 coincident with ram_req=1 SHALL accept nothing.

Verification
REQ-023 Write 0xDEADBEEF to 0x10 with byte_en=4'hF, then read 0x10 -> write response err=0 one cycle after accept; read response data=0xDEADBEEF, err=0, exactly 2 cycles after accept.
REQ-024 Write 0x11223344 with byte_en=4'hF, then write 0xAABBCCDD with byte_en=4'b0101 to 0x20, then read 0x20 -> data=0x11BB33DD.
REQ-025 Read 0x02 (misaligned) and read 0x400 with DEPTH_WORDS=256 -> each responds one cycle after accept with err=1, data=0; an erroring write to 0x401 leaves the array unchanged.
REQ-026 Hold ram_req=1 continuously with 3 reads -> ram_ready low during WAIT/RESP; exactly 3 responses, spaced READ_LATENCY+1=3 cycles apart.
REQ-027 Accept a read of 0x10, then assert rst for 1 cycle during WAIT -> no ram_resp_valid; ram_ready=1 one cycle after reset release; a subsequent read of 0x10 still returns 0xDEADBEEF.
REQ-028 READ_LATENCY=1, read 0x10 -> response in the cycle immediately after accept; back-to-back reads every 2 cycles.

Source files
------------

// File: rtl/lsu_ram_responder.sv
// Single-port word RAM answering LSU loads and stores with a fixed read latency.
// One request in flight; byte-lane stores, range/alignment error responses.
module lsu_ram_responder #(
    parameter int          DEPTH_WORDS  = 256,
    parameter int          READ_LATENCY = 2,
    parameter logic [31:0] BASE_ADDR    = 32'h0000_0000
) (
    input  logic        clk,
    input  logic        rst,
    input  logic        ram_req,
    input  logic        ram_write_enable,
    input  logic [31:0] ram_address,
    input  logic [31:0] ram_data_in,
    input  logic [3:0]  ram_byte_en,
    output logic        ram_ready,
    output logic [31:0] ram_data_out,
    output logic        ram_resp_valid,
    output logic        ram_err
);

    localparam int AW = (DEPTH_WORDS > 1) ? $clog2(DEPTH_WORDS) : 1;

    typedef enum logic [1:0] {
        IDLE,
        WAIT,
        RESP
    } state_t;

    state_t      state;
    logic [3:0]  cnt;
    logic [31:0] rd_q;
    logic [31:0] mem [DEPTH_WORDS];

    logic [31:0]   word;
    logic [AW-1:0] idx;
    logic          req_err;
    logic          accept;

    // A wrapped subtraction lands far above DEPTH_WORDS and is caught here too.
    assign word    = (ram_address - BASE_ADDR) >> 2;
    assign idx     = word[AW-1:0];
    assign req_err = (ram_address[1:0] != 2'b00)
                   || (ram_address < BASE_ADDR)
                   || (word >= 32'(DEPTH_WORDS));
    assign accept  = ram_req && ram_ready && !rst;

    always_ff @(posedge clk) begin
        if (accept && ram_write_enable && !req_err) begin
            for (int i = 0; i < 4; i++) begin
                if (ram_byte_en[i]) begin
                    mem[idx][8*i +: 8] <= ram_data_in[8*i +: 8];
                end
            end
        end
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state          <= IDLE;
            cnt            <= 4'd0;
            rd_q           <= 32'd0;
            ram_ready      <= 1'b0;
            ram_resp_valid <= 1'b0;
            ram_err        <= 1'b0;
            ram_data_out   <= 32'd0;
        end else begin
            unique case (state)
                IDLE: begin
                    ram_ready <= 1'b1;
                    if (accept) begin
                        ram_ready <= 1'b0;
                        if (req_err || ram_write_enable) begin
                            state          <= RESP;
                            ram_resp_valid <= 1'b1;
                            ram_err        <= req_err;
                            ram_data_out   <= 32'd0;
                        end else if (READ_LATENCY == 1) begin
                            state          <= RESP;
                            ram_resp_valid <= 1'b1;
                            ram_err        <= 1'b0;
                            ram_data_out   <= mem[idx];
                        end else begin
                            state <= WAIT;
                            cnt   <= 4'(READ_LATENCY - 2);
                            rd_q  <= mem[idx];
                        end
                    end
                end
                WAIT: begin
                    if (cnt == 4'd0) begin
                        state          <= RESP;
                        ram_resp_valid <= 1'b1;
                        ram_err        <= 1'b0;
                        ram_data_out   <= rd_q;
                    end else begin
                        cnt <= cnt - 4'd1;
                    end
                end
                RESP: begin
                    state          <= IDLE;
                    ram_ready      <= 1'b1;
                    ram_resp_valid <= 1'b0;
                    ram_err        <= 1'b0;
                    ram_data_out   <= 32'd0;
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule
